cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 20 ++
 rtl/cdb_arbiter_fifo.sv | 48 ++++
 rtl/cdb_arbiter.sv | 103 ++++++++++
 tb/tb_cdb_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared machine-wide sizes and the common data bus (CDB) entry type.
// Also holds the default depth of the CDB result queues.
package cdb_arbiter_pkg;

  localparam int RS_SIZE        = 16;
  localparam int ROB_SIZE       = 16;
  localparam int ROB_POS_WID    = $clog2(ROB_SIZE);
  localparam int CDB_FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0]            val;
    logic [ROB_POS_WID-1:0] rob_pos;
  } cdb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// cdb_fifo: small synchronous FIFO feeding one source's results into the CDB arbiter.
// The caller guarantees no push when full and no pop when empty.
module cdb_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: queues ALU and LSB results and broadcasts one per cycle on the CDB.
// Define CDB_RR_EN for round-robin arbitration; default is fixed LSB-over-ALU priority.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   rollback,
  input  logic                   alu_valid,
  input  logic [31:0]            alu_val,
  input  logic [ROB_POS_WID-1:0] alu_rob_pos,
  output logic                   alu_ready,
  input  logic                   lsb_valid,
  input  logic [31:0]            lsb_val,
  input  logic [ROB_POS_WID-1:0] lsb_rob_pos,
  output logic                   lsb_ready,
  output logic                   cdb_valid,
  output logic [31:0]            cdb_val,
  output logic [ROB_POS_WID-1:0] cdb_rob_pos
);

  cdb_entry_t alu_din, lsb_din, alu_head, lsb_head, win_p0;
  logic alu_full, alu_empty, lsb_full, lsb_empty;
  logic en, flush;
  logic alu_push, lsb_push, alu_pop, lsb_pop, grant_lsb;

  assign en    = rdy && !rollback;
  assign flush = rdy && rollback;

  assign alu_ready = !alu_full;
  assign lsb_ready = !lsb_full;

  assign alu_din = '{val: alu_val, rob_pos: alu_rob_pos};
  assign lsb_din = '{val: lsb_val, rob_pos: lsb_rob_pos};

  assign alu_push = en && alu_valid && alu_ready;
  assign lsb_push = en && lsb_valid && lsb_ready;

  cdb_fifo #(.DATA_W($bits(cdb_entry_t)), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (alu_push),
    .pop   (alu_pop),
    .din   (alu_din),
    .dout  (alu_head),
    .full  (alu_full),
    .empty (alu_empty)
  );

  cdb_fifo #(.DATA_W($bits(cdb_entry_t)), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .din   (lsb_din),
    .dout  (lsb_head),
    .full  (lsb_full),
    .empty (lsb_empty)
  );

`ifdef CDB_RR_EN
  cdb_src_e last_grant;

  // LSB wins only if ALU has nothing or ALU was the previous winner.
  always_comb begin
    grant_lsb = 1'b0;
    if (!lsb_empty && (alu_empty || last_grant == SRC_ALU)) grant_lsb = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)          last_grant <= SRC_LSB;
    else if (alu_pop) last_grant <= SRC_ALU;
    else if (lsb_pop) last_grant <= SRC_LSB;
  end
`else
  assign grant_lsb = !lsb_empty;
`endif

  assign lsb_pop = en && grant_lsb;
  assign alu_pop = en && !alu_empty && !grant_lsb;
  assign win_p0  = grant_lsb ? lsb_head : alu_head;

  // p0 -> output register: selected head becomes the broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid   <= 1'b0;
      cdb_val     <= '0;
      cdb_rob_pos <= '0;
    end else if (rdy) begin
      cdb_valid <= alu_pop || lsb_pop;
      if (alu_pop || lsb_pop) begin
        cdb_val     <= win_p0.val;
        cdb_rob_pos <= win_p0.rob_pos;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter, with expectations for both arbitration modes.
// Define CDB_RR_EN together with the RTL to select round-robin expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

`ifdef CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, rdy, rollback;
  logic                   alu_valid, lsb_valid, alu_ready, lsb_ready;
  logic [31:0]            alu_val, lsb_val, cdb_val;
  logic [ROB_POS_WID-1:0] alu_rob_pos, lsb_rob_pos, cdb_rob_pos;
  logic                   cdb_valid;

  always #5 clk = ~clk;

  cdb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .rollback    (rollback),
    .alu_valid   (alu_valid),
    .alu_val     (alu_val),
    .alu_rob_pos (alu_rob_pos),
    .alu_ready   (alu_ready),
    .lsb_valid   (lsb_valid),
    .lsb_val     (lsb_val),
    .lsb_rob_pos (lsb_rob_pos),
    .lsb_ready   (lsb_ready),
    .cdb_valid   (cdb_valid),
    .cdb_val     (cdb_val),
    .cdb_rob_pos (cdb_rob_pos)
  );

  typedef struct {
    bit                     rst, rdy, rb, av, lv;
    logic [31:0]            aval, lval, val;
    logic [ROB_POS_WID-1:0] apos, lpos, pos;
    bit                     cv, ar, lr;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(bit rst_i, bit rdy_i, bit rb_i,
                              bit av_i, logic [31:0] aval_i, int apos_i,
                              bit lv_i, logic [31:0] lval_i, int lpos_i,
                              bit cv_i, logic [31:0] val_i, int pos_i,
                              bit ar_i, bit lr_i);
    vec_t v;
    v.rst = rst_i; v.rdy = rdy_i; v.rb = rb_i;
    v.av = av_i; v.aval = aval_i; v.apos = ROB_POS_WID'(apos_i);
    v.lv = lv_i; v.lval = lval_i; v.lpos = ROB_POS_WID'(lpos_i);
    v.cv = cv_i; v.val = val_i; v.pos = ROB_POS_WID'(pos_i);
    v.ar = ar_i; v.lr = lr_i;
    vecs.push_back(v);
  endfunction

  function automatic void idle(bit cv_i, logic [31:0] val_i, int pos_i, bit ar_i, bit lr_i);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, cv_i, val_i, pos_i, ar_i, lr_i);
  endfunction

  function automatic void do_reset();
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endfunction

  initial begin
    int pulses, first;

    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    alu_valid = 1'b0; alu_val = '0; alu_rob_pos = '0;
    lsb_valid = 1'b0; lsb_val = '0; lsb_rob_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cv",  32'(cdb_valid), 0);
    chk("rst_val", cdb_val, 0);
    chk("rst_pos", 32'(cdb_rob_pos), 0);
    chk("rst_ar",  32'(alu_ready), 1);
    chk("rst_lr",  32'(lsb_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // single ALU result: two-edge latency, one-cycle pulse
    add(0, 1, 0, 1, 'h11, 3, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1, 'h11, 3, 1, 1);
    idle(0, 'h11, 3, 1, 1);

    // simultaneous push from both sources
    do_reset();
    add(0, 1, 0, 1, 'hA, 1, 1, 'hB, 2, 0, 0, 0, 1, 1);
    idle(1, RR ? 'hA : 'hB, RR ? 1 : 2, 1, 1);
    idle(1, RR ? 'hB : 'hA, RR ? 2 : 1, 1, 1);
    idle(0, RR ? 'hB : 'hA, RR ? 2 : 1, 1, 1);

    // ALU queue fills while LSB streams
    do_reset();
`ifdef CDB_RR_EN
    add(0, 1, 0, 1, 'h100, 0, 1, 'h200, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 'h101, 1, 1, 'h201, 1, 1, 'h100, 0, 1, 0);
    add(0, 1, 0, 1, 'h102, 2, 1, 'h202, 2, 1, 'h200, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 'h202, 2, 1, 'h101, 1, 1, 0);
    idle(1, 'h201, 1, 1, 1);
    idle(1, 'h102, 2, 1, 1);
    idle(1, 'h202, 2, 1, 1);
    idle(0, 'h202, 2, 1, 1);
`else
    add(0, 1, 0, 1, 'h100, 0, 1, 'h200, 0, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 'h101, 1, 1, 'h201, 1, 1, 'h200, 0, 0, 1);
    add(0, 1, 0, 1, 'h102, 2, 1, 'h202, 2, 1, 'h201, 1, 0, 1);
    add(0, 1, 0, 1, 'h102, 2, 0, 0, 0, 1, 'h202, 2, 0, 1);
    add(0, 1, 0, 1, 'h102, 2, 0, 0, 0, 1, 'h100, 0, 1, 1);
    add(0, 1, 0, 1, 'h102, 2, 0, 0, 0, 1, 'h101, 1, 1, 1);
    idle(1, 'h102, 2, 1, 1);
    idle(0, 'h102, 2, 1, 1);
`endif

    // rollback with entries queued and a fresh offer in the same cycle
    do_reset();
    add(0, 1, 0, 1, 'h300, 4, 1, 'h400, 4, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 'h301, 5, 1, 'h401, 5, 1, RR ? 'h300 : 'h400, 4, RR, !RR);
    add(0, 1, 1, 1, 'h3ff, 6, 1, 'h4ff, 6, 0, RR ? 'h300 : 'h400, 4, 1, 1);
    idle(0, RR ? 'h300 : 'h400, 4, 1, 1);
    idle(0, RR ? 'h300 : 'h400, 4, 1, 1);

    // rdy low freezes everything, including offered pushes and rollback
    do_reset();
    add(0, 1, 0, 1, 'h500, 6, 1, 'h600, 7, 0, 0, 0, 1, 1);
    add(0, 1, 0, 1, 'h501, 8, 0, 0, 0, 1, RR ? 'h500 : 'h600, RR ? 6 : 7, RR, 1);
    for (int k = 0; k < 3; k++)
      add(0, 0, k == 1, 1, 'h5ff, 9, 1, 'h6ff, 9, 1, RR ? 'h500 : 'h600, RR ? 6 : 7, RR, 1);
    idle(1, RR ? 'h600 : 'h500, RR ? 7 : 6, 1, 1);
    idle(1, 'h501, 8, 1, 1);
    idle(0, 'h501, 8, 1, 1);

    // reset while rdy is low drops queued results
    do_reset();
    add(0, 1, 0, 1, 'h700, 10, 1, 'h800, 11, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 0, 0, 1, 1);
    idle(0, 0, 0, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; rdy = vecs[i].rdy; rollback = vecs[i].rb;
      alu_valid = vecs[i].av; alu_val = vecs[i].aval; alu_rob_pos = vecs[i].apos;
      lsb_valid = vecs[i].lv; lsb_val = vecs[i].lval; lsb_rob_pos = vecs[i].lpos;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cv", i),  32'(cdb_valid), 32'(vecs[i].cv));
      chk($sformatf("v%0d_val", i), cdb_val, vecs[i].val);
      chk($sformatf("v%0d_pos", i), 32'(cdb_rob_pos), 32'(vecs[i].pos));
      chk($sformatf("v%0d_ar", i),  32'(alu_ready), 32'(vecs[i].ar));
      chk($sformatf("v%0d_lr", i),  32'(lsb_ready), 32'(vecs[i].lr));
    end

    // one accepted result is broadcast exactly once, one edge after acceptance
    @(negedge clk);
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; lsb_valid = 1'b0;
    alu_valid = 1'b1; alu_val = 32'h900; alu_rob_pos = ROB_POS_WID'(12);
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    pulses = 0;
    first  = -1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (cdb_valid) begin
        pulses++;
        if (first < 0) first = c;
        chk("hs_val", cdb_val, 32'h900);
        chk("hs_pos", 32'(cdb_rob_pos), 12);
      end
    end
    chk("hs_pulses", 32'(pulses), 1);
    chk("hs_latency", 32'(first), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
